mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between two requesters: instruction fetch (I, read-only) and data load/store (D).
- Sequences each access through the memory: issue, latency wait, response.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the control FSM/datapath memory-flag outputs and the unified memory, and replaces separate instruction and data memory ports.

Parameters:
AW, 32, address width
DW, 32, data width
LATENCY, 2, cycles from issue cycle to mem_rdata valid (legal range 1..15)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
i_req  in  1  fetch request; held until i_ack
i_addr  in  AW  fetch address
i_ack  out  1  one-cycle pulse; fetch complete
i_rdata  out  DW  fetched word; valid from i_ack, held until next i_ack
i_err  out  1  valid with i_ack; misaligned address
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse; data access complete
d_rdata  out  DW  load data; valid from d_ack, held until next d_ack
d_err  out  1  valid with d_ack; misaligned address
mem_req  out  1  memory strobe, exactly one cycle per access
mem_we  out  1  memory write enable; qualified by mem_req
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid LATENCY cycles after the mem_req cycle
busy  out  1  high in every state except IDLE
grant_d  out  1  1 = current or last grant went to D

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - state = IDLE; all ack, err and mem_req/mem_we = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - busy = 0; grant_d = 0; wait counter = 0.
  - last_grant = I, so D wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples i_req and d_req.
  - If only one request is high, grant it. If both are high, grant the requester not in last_grant (round-robin).
  - On grant: latch requester id, address, we (forced 0 for I) and wdata into internal registers; update last_grant.
  - If latched addr[1:0] != 0: go to RESP with err flag set; no memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req = 1, mem_we = latched we, mem_addr/mem_wdata = latched values. All four are registered outputs, stable for the whole cycle.
  - Load counter = LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter equals 1, mem_rdata is valid. On that edge, capture it into the granted requester's rdata register (loads and fetches only; stores leave rdata unchanged). Then go to RESP.
  - mem_req = 0 throughout WAIT.
- RESP:
  - Granted requester's ack = 1 for exactly one cycle; err = 1 only on the misaligned path.
  - Next state is always IDLE. Requests are ignored during RESP.
  - The requester may keep req high through the ack cycle; it must drop req the following cycle, or that cycle is a new request.
- Latency, aligned access: req seen in IDLE at cycle 0 → ISSUE at cycle 1 → ack at cycle LATENCY+2.
- Latency, misaligned access: ack at cycle 1.
- Throughput: at most one access in flight; the next grant is in the cycle after RESP.
- The non-granted requester's ack stays 0 and its rdata is untouched.
- No request while IDLE → remains IDLE; no memory activity.
- Reset asserted in any state: next cycle is IDLE with reset values. An in-flight access is dropped with no ack; late mem_rdata is ignored.
- Counter width is 4 bits. LATENCY = 1 → WAIT lasts one cycle.

Test Plan:
- Single fetch, LATENCY=2: i_req with i_addr=0x100 at cycle 0, memory returns 0xDEADBEEF → mem_req=1 with mem_we=0 and mem_addr=0x100 only at cycle 1; i_ack at cycle 4; i_rdata=0xDEADBEEF; i_err=0; d_ack never asserted.
- Store: d_req, d_we=1, d_addr=0x204, d_wdata=0x12345678 → mem_we=1 with mem_wdata=0x12345678 at cycle 1; d_ack at cycle 4; d_rdata unchanged (0 after reset).
- Tie round-robin: i_req and d_req both held from reset → grants in order D, I, D, I; grant_d toggles; each ack exactly one cycle; 4 accesses complete in 4×(LATENCY+3) cycles.
- Misaligned: d_req with d_addr=0x203 → d_ack and d_err=1 at cycle 1; mem_req stays 0 throughout.
- Reset mid-access: assert reset during WAIT → next cycle IDLE, busy=0, no ack. A subsequent i_req completes normally with the correct latency.
- LATENCY=1 build: fetch with i_addr=0x0 → i_ack at cycle 3; data sampled in the single WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data load-store) in front of one
// single-ported fixed-latency memory. One access in flight, round-robin on ties.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_d,
  output logic [1:0]    dbgState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Handshake: a requester raises req with stable address/data and holds it
  // until its ack pulse; req still high in the cycle after ack is a new request.

  logic [1:0]    state;
  logic [3:0]    waitCnt;
  logic          weQ;
  logic          pickD;
  logic [AW-1:0] selAddr;

  // grant_d doubles as last_grant: 0 after reset means D wins the first tie.
  always_comb begin
    pickD = d_req;
    if (i_req && d_req) pickD = !grant_d;
    selAddr = pickD ? d_addr : i_addr;
  end

  assign busy     = (state != IDLE);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      weQ       <= 1'b0;
      grant_d   <= 1'b0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d   <= pickD;
            mem_addr  <= selAddr;
            mem_wdata <= pickD ? d_wdata : '0;
            weQ       <= pickD & d_we;
            if (selAddr[1:0] != 2'b00) begin
              // Misaligned: answer straight away, memory never strobed.
              state <= RESP;
              if (pickD) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                i_ack <= 1'b1;
                i_err <= 1'b1;
              end
            end else begin
              state   <= ISSUE;
              mem_req <= 1'b1;
              mem_we  <= pickD & d_we;
            end
          end
        end
        ISSUE: begin
          waitCnt <= 4'(LATENCY);
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == 4'd1) begin
            waitCnt <= 4'd0;
            state   <= RESP;
            if (grant_d) begin
              d_ack <= 1'b1;
              if (!weQ) d_rdata <= mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, and a randomized run against a transaction-timing model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata;
  logic          i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy, grant_d;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_d(grant_d), .dbgState(dbg_state)
  );

  // LATENCY=1 build
  logic          reset1 = 1'b1, i_req1 = 1'b0;
  logic [AW-1:0] i_addr1 = '0;
  logic [DW-1:0] mem_rdata1;
  logic          i_ack1, i_err1, d_ack1, d_err1, mem_req1, mem_we1, busy1, grant_d1;
  logic [DW-1:0] i_rdata1, d_rdata1, mem_wdata1;
  logic [AW-1:0] mem_addr1;
  logic [1:0]    dbg_state1;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1), .i_err(i_err1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .grant_d(grant_d1), .dbgState(dbg_state1)
  );

  // ---------------- memory models ----------------
  // Read data is driven only for the one cycle LAT after the strobe; garbage otherwise.
  logic [31:0] mem_arr [logic [31:0]];
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  always @(negedge clk) begin
    if (pend_cnt == 1)
      mem_rdata = mem_arr.exists(pend_addr) ? mem_arr[pend_addr] : init_val(pend_addr);
    else
      mem_rdata = $urandom();
    if (pend_cnt != 0) pend_cnt--;
    if (mem_req) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else begin
        pend_cnt  = LAT;
        pend_addr = mem_addr;
      end
    end
  end

  logic seen1 = 1'b0;
  always @(negedge clk) begin
    mem_rdata1 = seen1 ? 32'h1111_1111 : $urandom();
    seen1 = mem_req1;
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_ack_cyc;
    logic        exp_err;
    logic        exp_mreq;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int idx, input vec_t v);
    int ack_at = -1, mreq_at = -1, mreq_n = 0, other_n = 0, ack_n = 0;
    logic got_err = 1'b0, got_we = 1'b0;
    logic [31:0] got_addr = '0, got_wdata = '0, got_rdata = '0;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_req) begin
        mreq_n++; mreq_at = k;
        got_we = mem_we; got_addr = mem_addr; got_wdata = mem_wdata;
      end
      if (v.is_d ? d_ack : i_ack) begin
        ack_n++;
        if (ack_at < 0) begin
          ack_at    = k;
          got_err   = v.is_d ? d_err : i_err;
          got_rdata = v.is_d ? d_rdata : i_rdata;
        end
      end
      if (v.is_d ? i_ack : d_ack) other_n++;
      if (k == ack_at) begin
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk($sformatf("v%0d_ack_cycle", idx), ack_at, v.exp_ack_cyc);
    chk($sformatf("v%0d_ack_count", idx), ack_n, 1);
    chk($sformatf("v%0d_other_ack", idx), other_n, 0);
    chk($sformatf("v%0d_err", idx), got_err, v.exp_err);
    chk($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rdata_held", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    chk($sformatf("v%0d_mreq_count", idx), mreq_n, v.exp_mreq ? 1 : 0);
    if (v.exp_mreq) begin
      chk($sformatf("v%0d_mreq_cycle", idx), mreq_at, 1);
      chk($sformatf("v%0d_mem_we", idx), got_we, v.we);
      chk($sformatf("v%0d_mem_addr", idx), got_addr, v.addr);
      if (v.we) chk($sformatf("v%0d_mem_wdata", idx), got_wdata, v.wdata);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem_arr[32'h100]  = 32'hDEADBEEF;
    mem_arr[32'h104]  = 32'hCAFEF00D;
    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,      LAT + 2, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h204, 32'h12345678, LAT + 2, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h204, 32'h0,      LAT + 2, 1'b0, 1'b1, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h203, 32'h0,      1,       1'b1, 1'b0, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 32'h102, 32'h0,      1,       1'b1, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h104, 32'h0,      LAT + 2, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b1, 32'h201, 32'hFFFF,   1,       1'b1, 1'b0, 32'h12345678};

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ack", i_ack, 0);   chk("rst_d_ack", d_ack, 0);
    chk("rst_i_err", i_err, 0);   chk("rst_d_err", d_err, 0);
    chk("rst_mem_req", mem_req, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);     chk("rst_grant_d", grant_d, 0);
    @(posedge clk); #1; reset = 1'b0;

    // idle with no requests
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_mem_req", mem_req, 0);
      chk("idle_busy", busy, 0);
    end

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // round-robin tie from reset: D, I, D, I
    begin
      int ack_n = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
      @(posedge clk); #1; reset = 1'b0;
      for (int k = 0; k < 4 * (LAT + 3); k++) begin
        @(negedge clk);
        chk("rr_both_ack", i_ack & d_ack, 0);
        if (i_ack || d_ack) begin
          chk("rr_ack_cycle", k, ack_n * (LAT + 3) + LAT + 2);
          chk("rr_who_d", d_ack, (ack_n % 2) == 0);
          chk("rr_grant_d", grant_d, (ack_n % 2) == 0);
          chk("rr_rdata", d_ack ? d_rdata : i_rdata, d_ack ? 32'h12345678 : 32'hDEADBEEF);
          ack_n++;
        end
      end
      chk("rr_count", ack_n, 4);
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
    end

    // reset during WAIT drops the access
    begin
      int late_acks = 0;
      @(posedge clk); #1; i_req = 1'b1; i_addr = 32'h100;   // cycle 0
      @(posedge clk);                                         // cycle 1 ISSUE
      @(posedge clk); #1; reset = 1'b1; i_req = 1'b0;        // cycle 2 WAIT
      @(posedge clk); #1; reset = 1'b0;                       // cycle 3
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_state", dbg_state, 0);
      chk("midrst_i_rdata", i_rdata, 0);
      chk("midrst_grant_d", grant_d, 0);
      late_acks += i_ack;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        late_acks += i_ack + d_ack + mem_req;
      end
      chk("midrst_no_ack", late_acks, 0);
      run_vec(100, vecs[0]);
    end

    // LATENCY=1 build
    begin
      int ack_at = -1, mreq_n = 0;
      logic [31:0] got = '0;
      @(posedge clk); #1; reset1 = 1'b0;
      @(posedge clk); #1; i_req1 = 1'b1; i_addr1 = 32'h0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        mreq_n += mem_req1;
        if (i_ack1 && ack_at < 0) begin ack_at = k; got = i_rdata1; end
        if (k == ack_at) begin @(posedge clk); #1; i_req1 = 1'b0; end
      end
      i_req1 = 1'b0;
      chk("lat1_ack_cycle", ack_at, 3);
      chk("lat1_rdata", got, 32'h1111_1111);
      chk("lat1_mreq_count", mreq_n, 1);
    end

    // randomized run against transaction-timing model
    begin
      bit          i_pend = 0, d_pend = 0, act = 0, resp_now, exp_mreq;
      bit          cur_d = 0, cur_we = 0, cur_mis = 0, last_d = 0;
      logic [31:0] cur_addr = '0, cur_wdata = '0, exp_ir = '0, exp_dr = '0;
      int          start_cyc = 0, ack_cyc = 0;
      @(posedge clk); #1; reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1; reset = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        @(posedge clk); #1;
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          i_pend = 1; i_addr = rand_addr();
        end
        i_req = i_pend;
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom();
        end
        d_req = d_pend;
        @(negedge clk);
        resp_now = act && (k == ack_cyc);
        exp_mreq = act && !cur_mis && (k == start_cyc + 1);
        if (resp_now && !cur_mis && !cur_we) begin
          if (cur_d) exp_dr = ref_rd(cur_addr);
          else       exp_ir = ref_rd(cur_addr);
        end
        chk("rnd_i_ack", i_ack, resp_now && !cur_d);
        chk("rnd_d_ack", d_ack, resp_now && cur_d);
        chk("rnd_i_err", i_err, resp_now && !cur_d && cur_mis);
        chk("rnd_d_err", d_err, resp_now && cur_d && cur_mis);
        chk("rnd_i_rdata", i_rdata, exp_ir);
        chk("rnd_d_rdata", d_rdata, exp_dr);
        chk("rnd_mem_req", mem_req, exp_mreq);
        chk("rnd_busy", busy, act && (k > start_cyc));
        chk("rnd_grant_d", grant_d, last_d);
        if (exp_mreq) begin
          chk("rnd_mem_we", mem_we, cur_we);
          chk("rnd_mem_addr", mem_addr, cur_addr);
          if (cur_we) begin
            chk("rnd_mem_wdata", mem_wdata, cur_wdata);
            ref_mem[cur_addr] = cur_wdata;
          end
        end
        if (resp_now) begin
          act = 0;
          if (cur_d) d_pend = 0; else i_pend = 0;
        end else if (!act && (i_pend || d_pend)) begin
          cur_d     = (i_pend && d_pend) ? !last_d : d_pend;
          last_d    = cur_d;
          cur_addr  = cur_d ? d_addr : i_addr;
          cur_we    = cur_d && d_we;
          cur_wdata = d_wdata;
          cur_mis   = (cur_addr[1:0] != 2'b00);
          start_cyc = k;
          ack_cyc   = k + (cur_mis ? 1 : LAT + 2);
          act       = 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
